// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default width, shifter mode select.
// No logic; no latency; no flow control.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for SLL / SRL / SRA.
// Combinational, zero latency; no flow control.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   i_value,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  shift_mode_e        i_mode,
    output logic [WIDTH-1:0]   o_result
);

    always_comb begin
        o_result = i_value;
        case (i_mode)
            SH_SLL:  o_result = i_value << i_shamt;
            SH_SRL:  o_result = i_value >> i_shamt;
            SH_SRA:  o_result = $unsigned($signed(i_value) >>> i_shamt);
            default: o_result = i_value;
        endcase
    end

endmodule

// File: rtl/alu32.sv
// 32-bit integer ALU with registered result and branch compare flags.
// One cycle latency; accepts a new operation every cycle, never stalls.
module alu32
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    input  logic [3:0]       OPCODE,
    output logic [WIDTH-1:0] RESULT,
    output logic             LT,
    output logic             LTU,
    output logic             EQ
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_result;
    logic             w_lt;
    logic             w_ltu;
    logic             w_eq;
    shift_mode_e      w_mode;

    logic [WIDTH-1:0] r_result;
    logic             r_lt;
    logic             r_ltu;
    logic             r_eq;

    assign w_sum  = OP1 + OP2;
    assign w_diff = OP1 - OP2;
    assign w_lt   = $signed(OP1) < $signed(OP2);
    assign w_ltu  = OP1 < OP2;
    assign w_eq   = OP1 == OP2;

    always_comb begin
        w_mode = SH_SLL;
        if (OPCODE == OP_SRL) begin
            w_mode = SH_SRL;
        end else if (OPCODE == OP_SRA) begin
            w_mode = SH_SRA;
        end
    end

    // Only the low SHAMT_W bits of OP2 reach the shifter.
    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .i_value  (OP1),
        .i_shamt  (OP2[SHAMT_W-1:0]),
        .i_mode   (w_mode),
        .o_result (w_shift)
    );

    always_comb begin
        w_result = '0;
        case (OPCODE)
            OP_ADD:  w_result = w_sum;
            OP_SUB:  w_result = w_diff;
            OP_SLL,
            OP_SRL,
            OP_SRA:  w_result = w_shift;
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
            OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_ltu};
            OP_XOR:  w_result = OP1 ^ OP2;
            OP_OR:   w_result = OP1 | OP2;
            OP_AND:  w_result = OP1 & OP2;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_lt     <= 1'b0;
            r_ltu    <= 1'b0;
            r_eq     <= 1'b0;
        end else begin
            r_result <= w_result;
            r_lt     <= w_lt;
            r_ltu    <= w_ltu;
            r_eq     <= w_eq;
        end
    end

    assign RESULT = r_result;
    assign LT     = r_lt;
    assign LTU    = r_ltu;
    assign EQ     = r_eq;

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed vectors per feature plus a random pipelined stream.
// Expected results are queued at drive time and popped one edge later.
module tb_alu32;

    typedef struct {
        logic [31:0] res;
        logic        lt;
        logic        ltu;
        logic        eq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic [3:0]  OPCODE;
    logic [31:0] RESULT;
    logic        LT;
    logic        LTU;
    logic        EQ;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    alu32 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .OP1    (OP1),
        .OP2    (OP2),
        .OPCODE (OPCODE),
        .RESULT (RESULT),
        .LT     (LT),
        .LTU    (LTU),
        .EQ     (EQ)
    );

    always #5 clk = ~clk;

    // Signed order obtained by biasing both operands, then comparing unsigned.
    function automatic logic m_lt(input logic [31:0] a, input logic [31:0] b);
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        exp_t e;
        e.res = res;
        e.lt  = m_lt(a, b);
        e.ltu = a < b;
        e.eq  = a == b;
        return e;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [4:0]  sh;
        logic [31:0] r;
        sh = b[4:0];
        r  = 32'h0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a << sh;
            4'd3: r = {31'h0, m_lt(a, b)};
            4'd4: r = {31'h0, a < b};
            4'd5: r = a ^ b;
            4'd6: r = a >> sh;
            4'd7: begin
                r = a;
                for (int k = 0; k < int'(sh); k++) r = {r[31], r[31:1]};
            end
            4'd8: r = a | b;
            4'd9: r = a & b;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        exp_t e;
        rst_n  = 1'b0;
        OPCODE = 4'd0;
        OP1    = 32'h0005_5555;
        OP2    = 32'h000A_AAAA;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (RESULT !== 32'h0 || LT !== 1'b0 || LTU !== 1'b0 || EQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got res=%h lt=%b ltu=%b eq=%b, want all zero", RESULT, LT, LTU, EQ);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(OP1, OP2, 32'h000F_FFFF));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (RESULT !== e.res || LT !== e.lt || LTU !== e.ltu || EQ !== e.eq) begin
            errors++;
            $display("FAIL reset_release: got res=%h lt=%b ltu=%b eq=%b, want res=%h lt=%b ltu=%b eq=%b",
                     RESULT, LT, LTU, EQ, e.res, e.lt, e.ltu, e.eq);
        end
    endtask

    task automatic run_table(input string name, input logic [31:0] a[], input logic [31:0] b[],
                             input logic [3:0] op[], input logic [31:0] r[]);
        exp_t e;
        for (int i = 0; i < a.size(); i++) begin
            @(negedge clk);
            OP1 = a[i]; OP2 = b[i]; OPCODE = op[i];
            sb.push_back(mk(a[i], b[i], r[i]));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (RESULT !== e.res || LT !== e.lt || LTU !== e.ltu || EQ !== e.eq) begin
                errors++;
                $display("FAIL %s[%0d]: got res=%h lt=%b ltu=%b eq=%b, want res=%h lt=%b ltu=%b eq=%b",
                         name, i, RESULT, LT, LTU, EQ, e.res, e.lt, e.ltu, e.eq);
            end
        end
    endtask

    task automatic test_arith();
        logic [31:0] a[]  = '{32'h55555, 32'h55555, 32'h55555, 32'hFFFF_FFFF};
        logic [31:0] b[]  = '{32'h55555, 32'hAAAAA, 32'h33333, 32'h1};
        logic [3:0]  op[] = '{4'd0, 4'd1, 4'd1, 4'd0};
        logic [31:0] r[]  = '{32'hAAAAA, 32'hFFFA_AAAB, 32'h22222, 32'h0};
        run_table("arith", a, b, op, r);
    endtask

    task automatic test_shift();
        logic [31:0] a[]  = '{32'h55555, 32'h55555, 32'h55555, 32'h8000_0000, 32'h8000_0000,
                              32'h55555, 32'h7FFF_FFFF, 32'h1234_5678, 32'h8000_0000};
        logic [31:0] b[]  = '{32'd1, 32'd31, 32'd3, 32'd4, 32'd4, 32'h25, 32'd4, 32'hFFFF_FFE0, 32'd31};
        logic [3:0]  op[] = '{4'd2, 4'd2, 4'd6, 4'd7, 4'd6, 4'd2, 4'd7, 4'd6, 4'd7};
        logic [31:0] r[]  = '{32'hAAAAA, 32'h8000_0000, 32'hAAAA, 32'hF800_0000, 32'h0800_0000,
                              32'hAA_AAA0, 32'h07FF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
        run_table("shift", a, b, op, r);
    endtask

    task automatic test_compare();
        logic [31:0] a[]   = '{32'h55555, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h55555, 32'h8000_0000};
        logic [31:0] b[]   = '{32'hAAAAA, 32'h1, 32'h1, 32'h55555, 32'h7FFF_FFFF};
        logic [3:0]  op[]  = '{4'd3, 4'd3, 4'd4, 4'd3, 4'd3};
        logic [31:0] r[]   = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h1};
        logic        lt[]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        ltu[] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        eq[]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            OP1 = a[i]; OP2 = b[i]; OPCODE = op[i];
            e.res = r[i]; e.lt = lt[i]; e.ltu = ltu[i]; e.eq = eq[i];
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (RESULT !== e.res || LT !== e.lt || LTU !== e.ltu || EQ !== e.eq) begin
                errors++;
                $display("FAIL compare[%0d]: got res=%h lt=%b ltu=%b eq=%b, want res=%h lt=%b ltu=%b eq=%b",
                         i, RESULT, LT, LTU, EQ, e.res, e.lt, e.ltu, e.eq);
            end
        end
    endtask

    task automatic test_logic();
        logic [31:0] a[]  = '{32'h55555, 32'h55555, 32'h55555, 32'h55555};
        logic [31:0] b[]  = '{32'hAAAAA, 32'h33333, 32'h33333, 32'hAAAAA};
        logic [3:0]  op[] = '{4'd5, 4'd8, 4'd9, 4'd9};
        logic [31:0] r[]  = '{32'hFFFFF, 32'h77777, 32'h11111, 32'h0};
        run_table("logic", a, b, op, r);
    endtask

    task automatic test_undef();
        logic [31:0] a[]  = '{32'h8000_0000, 32'h55555, 32'hFFFF_FFFF, 32'h1, 32'h7, 32'hDEAD_BEEF};
        logic [31:0] b[]  = '{32'h7FFF_FFFF, 32'h55555, 32'h1, 32'hFFFF_FFFF, 32'h3, 32'h1};
        logic [3:0]  op[] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        logic [31:0] r[]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_table("undef", a, b, op, r);
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] prev;
        logic [31:0] a, b;
        logic [3:0]  op;
        prev = RESULT;
        for (int i = 0; i < 48; i++) begin
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            if (i % 7 == 0) b = a;
            op = 4'(i % 16);
            @(negedge clk);
            OP1 = a; OP2 = b; OPCODE = op;
            sb.push_back(mk(a, b, model(a, b, op)));
            #1;
            checks++;
            if (RESULT !== prev) begin
                errors++;
                $display("FAIL b2b_hold[%0d]: got res=%h before edge, want res=%h", i, RESULT, prev);
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            prev = e.res;
            checks++;
            if (RESULT !== e.res || LT !== e.lt || LTU !== e.ltu || EQ !== e.eq) begin
                errors++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got res=%h lt=%b ltu=%b eq=%b, want res=%h lt=%b ltu=%b eq=%b",
                         i, op, a, b, RESULT, LT, LTU, EQ, e.res, e.lt, e.ltu, e.eq);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        @(negedge clk);
        OP1 = 32'h1; OP2 = 32'h2; OPCODE = 4'd0;
        sb.push_back(mk(OP1, OP2, 32'h3));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (RESULT !== e.res || LT !== e.lt || LTU !== e.ltu || EQ !== e.eq) begin
            errors++;
            $display("FAIL midrst_pre: got res=%h lt=%b ltu=%b eq=%b, want res=%h lt=%b ltu=%b eq=%b",
                     RESULT, LT, LTU, EQ, e.res, e.lt, e.ltu, e.eq);
        end
        @(negedge clk);
        OP1 = 32'h0000_0009; OP2 = 32'h0000_0004; OPCODE = 4'd1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (RESULT !== 32'h0 || LT !== 1'b0 || LTU !== 1'b0 || EQ !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got res=%h lt=%b ltu=%b eq=%b, want all zero", RESULT, LT, LTU, EQ);
        end
        @(posedge clk);
        #1;
        checks++;
        if (RESULT !== 32'h0 || LT !== 1'b0 || LTU !== 1'b0 || EQ !== 1'b0) begin
            errors++;
            $display("FAIL midrst_held: got res=%h lt=%b ltu=%b eq=%b, want all zero", RESULT, LT, LTU, EQ);
        end
        @(negedge clk);
        rst_n = 1'b1;
        OP1 = 32'h55555; OP2 = 32'hAAAAA; OPCODE = 4'd5;
        sb.push_back(mk(OP1, OP2, 32'hFFFFF));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (RESULT !== e.res || LT !== e.lt || LTU !== e.ltu || EQ !== e.eq) begin
            errors++;
            $display("FAIL midrst_post: got res=%h lt=%b ltu=%b eq=%b, want res=%h lt=%b ltu=%b eq=%b",
                     RESULT, LT, LTU, EQ, e.res, e.lt, e.ltu, e.eq);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_compare();
        test_logic();
        test_undef();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
